// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg: shared types and defaults for the PWM capture block.
// Holds the capture FSM state enum, the default counter width and
// stuck timeout, and the 3-sample majority helper used by the optional
// glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN).
package pwm_cap_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 4096;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      STUCK   = 2'd2
   } state_e;

   // Majority vote of three samples: any single-sample disagreement is outvoted.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/pwm_cap_sync.sv
// pwm_cap_sync: brings the asynchronous PWM input into the clock domain and
// produces a level plus a registered rising-edge strobe aligned to that level.
// With PWM_CAPTURE_GLITCH_FILTER_EN defined, a 3-sample majority filter sits
// after the synchronizer (2 extra cycles of latency, single-cycle pulses and
// dropouts rejected); otherwise the synchronizer output feeds edge detection.
module pwm_cap_sync
   import pwm_cap_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic s_level,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;
   logic lvl;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic h1_q, h1_d;
   logic h2_q, h2_d;
   logic filt_q, filt_d;
`endif

   // Next-state for synchronizer, optional filter history and edge detector.
   always_comb begin
      s1_d = pwm_in;
      s2_d = s1_q;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      h1_d   = s2_q;
      h2_d   = h1_q;
      filt_d = maj3(s2_q, h1_q, h2_q);
      lvl    = filt_q;
`else
      lvl    = s2_q;
`endif
      prev_d = lvl;
      // Registering the edge keeps it aligned with prev_q, which is the level
      // the measurement FSM accumulates into its high-time counter.
      rise_d = lvl & ~prev_q;
   end

   // All sampling flops clear on reset so no stale edge survives it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         h1_q   <= 1'b0;
         h2_q   <= 1'b0;
         filt_q <= 1'b0;
`endif
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         h1_q   <= h1_d;
         h2_q   <= h2_d;
         filt_q <= filt_d;
`endif
      end
   end

   assign s_level = prev_q;
   assign rise    = rise_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM waveform between
// consecutive rising edges, and flags a stuck input (0% or 100% duty) when no
// rising edge arrives within TIMEOUT cycles. Optional input glitch filter is
// enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             CLK100MHZ,
   input  logic             RST,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_cnt,
   output logic [CNT_W-1:0] high_cnt,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic s_level;
   logic rise;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;
   logic             stuck_lvl_q, stuck_lvl_d;

   pwm_cap_sync u_sync (
      .clk     (CLK100MHZ),
      .rst     (RST),
      .pwm_in  (pwm_in),
      .s_level (s_level),
      .rise    (rise)
   );

   // Measurement FSM; a rise always wins over a simultaneous timeout, and
   // the counters stop at TIMEOUT so they can never wrap.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      period_d    = period_q;
      high_d      = high_q;
      valid_d     = 1'b0;
      stuck_d     = stuck_q;
      stuck_lvl_d = stuck_lvl_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               // First edge only opens a period; nothing to report yet.
               state_d = MEASURE;
               cnt_d   = ONE_C;
               hi_d    = ONE_C;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d     = STUCK;
               stuck_d     = 1'b1;
               stuck_lvl_d = s_level;
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_d = cnt_q;
               high_d   = hi_q;
               valid_d  = 1'b1;
               cnt_d    = ONE_C;
               hi_d     = ONE_C;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d     = STUCK;
               stuck_d     = 1'b1;
               stuck_lvl_d = s_level;
            end else begin
               cnt_d = cnt_q + ONE_C;
               hi_d  = hi_q + {{(CNT_W-1){1'b0}}, s_level};
            end
         end
         STUCK: begin
            if (rise) begin
               // The period opened by this edge is measured but not reported
               // until the next edge closes it.
               state_d = MEASURE;
               stuck_d = 1'b0;
               cnt_d   = ONE_C;
               hi_d    = ONE_C;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any partial measurement.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
         stuck_lvl_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         period_q    <= period_d;
         high_q      <= high_d;
         valid_q     <= valid_d;
         stuck_q     <= stuck_d;
         stuck_lvl_q <= stuck_lvl_d;
      end
   end

   assign period_cnt  = period_q;
   assign high_cnt    = high_q;
   assign valid       = valid_q;
   assign stuck       = stuck_q;
   assign stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed-vector bench for pwm_capture (default parameters).
// Expected values are hand-computed; the glitch-filter build
// (PWM_CAPTURE_GLITCH_FILTER_EN) shifts latency and the glitch-case results.
module tb_pwm_capture;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 4096;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT_X   = 2;
`else
   localparam int LAT_X   = 0;
`endif

   logic             clk = 1'b0;
   logic             RST;
   logic             pwm_in;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             valid;
   logic             stuck;
   logic             stuck_level;

   int checks = 0;
   int errors = 0;
   int dbl    = 0;
   logic valid_prev = 1'b0;
   int vq_p[$];
   int vq_h[$];

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK100MHZ   (clk),
      .RST         (RST),
      .pwm_in      (pwm_in),
      .period_cnt  (period_cnt),
      .high_cnt    (high_cnt),
      .valid       (valid),
      .stuck       (stuck),
      .stuck_level (stuck_level)
   );

   always #5 clk = ~clk;

   // Record every reported measurement and any valid lasting more than a cycle.
   always @(negedge clk) begin
      if (valid) begin
         vq_p.push_back(int'(period_cnt));
         vq_h.push_back(int'(high_cnt));
         if (valid_prev) dbl <= dbl + 1;
      end
      valid_prev <= valid;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Present one input sample; it is captured by the next rising edge.
   task automatic step(input logic lvl);
      pwm_in = lvl;
      @(negedge clk);
   endtask

   task automatic run_period(input int p, input int h);
      for (int i = 0; i < p; i++) step(i < h);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step(1'b0);
      step(1'b0);
      RST = 1'b0;
      vq_p.delete();
      vq_h.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, int'(period_cnt), 0);
      chk({tag, "_high"},   int'(high_cnt),   0);
      chk({tag, "_valid"},  int'(valid),      0);
      chk({tag, "_stuck"},  int'(stuck),      0);
      chk({tag, "_slevel"}, int'(stuck_level), 0);
   endtask

   initial begin
      RST    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");

      // Input stuck low from reset release: timeout on the 4097th edge.
      RST = 1'b0;
      repeat (TIMEOUT) step(1'b0);
      #1;
      chk("stuck0_before", int'(stuck), 0);
      step(1'b0);
      #1;
      chk("stuck0_after", int'(stuck), 1);
      chk("stuck0_level", int'(stuck_level), 0);
      chk("stuck0_novalid", vq_p.size(), 0);

      // Latency: valid 3 (+filter) cycles after the closing rise is sampled.
      do_reset();
      repeat (5) step(1'b0);
      run_period(10, 3);
      step(1'b1);
      for (int i = 1; i <= 2 + LAT_X; i++) step(i < 3);
      #1;
      chk("lat_early", int'(valid), 0);
      step((3 + LAT_X) < 3);
      #1;
      chk("lat_valid", int'(valid), 1);
      chk("lat_period", int'(period_cnt), 10);
      chk("lat_high", int'(high_cnt), 3);
      step(1'b0);
      #1;
      chk("lat_one_cycle", int'(valid), 0);

      // Steady 256/64 for four periods: three reports.
      do_reset();
      repeat (4) run_period(256, 64);
      repeat (10) step(1'b0);
      chk("p256_count", vq_p.size(), 3);
      for (int i = 0; i < vq_p.size(); i++) begin
         chk("p256_period", vq_p[i], 256);
         chk("p256_high", vq_h[i], 64);
      end

      // 100/30 then held high: stuck at 1 with the last values held, then resume.
      do_reset();
      repeat (3) run_period(100, 30);
      repeat (TIMEOUT + 20) step(1'b1);
      #1;
      chk("hold1_stuck", int'(stuck), 1);
      chk("hold1_level", int'(stuck_level), 1);
      chk("hold1_period", int'(period_cnt), 100);
      chk("hold1_high", int'(high_cnt), 30);
      chk("hold1_count", vq_p.size(), 3);
      repeat (10) step(1'b0);
      run_period(100, 30);
      #1;
      chk("resume_unstuck", int'(stuck), 0);
      chk("resume_discard", vq_p.size(), 3);
      run_period(100, 30);
      repeat (10) step(1'b0);
      chk("resume_count", vq_p.size(), 4);
      if (vq_p.size() == 4) begin
         chk("resume_period", vq_p[3], 100);
         chk("resume_high", vq_h[3], 30);
      end

      // Reset 50 cycles into a period: everything clears, two rises needed.
      do_reset();
      repeat (2) run_period(256, 32);
      for (int i = 0; i < 50; i++) step(i < 32);
      RST = 1'b1;
      step(1'b0);
      #1;
      chk_zero("midrst");
      RST = 1'b0;
      vq_p.delete();
      vq_h.delete();
      for (int i = 51; i < 256; i++) step(1'b0);
      run_period(256, 32);
      chk("midrst_first_rise", vq_p.size(), 0);
      run_period(256, 32);
      repeat (10) step(1'b0);
      chk("midrst_count", vq_p.size(), 1);
      if (vq_p.size() == 1) begin
         chk("midrst_period", vq_p[0], 256);
         chk("midrst_high", vq_h[0], 32);
      end

      // 200/50 with a one-cycle glitch high at cycle 120 of the second period.
      do_reset();
      run_period(200, 50);
      for (int i = 0; i < 200; i++) step((i < 50) || (i == 120));
      run_period(200, 50);
      repeat (10) step(1'b0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      chk("glitch_count", vq_p.size(), 2);
      if (vq_p.size() == 2) begin
         chk("glitch_p0", vq_p[0], 200);
         chk("glitch_h0", vq_h[0], 50);
         chk("glitch_p1", vq_p[1], 200);
         chk("glitch_h1", vq_h[1], 50);
      end
`else
      chk("glitch_count", vq_p.size(), 3);
      if (vq_p.size() == 3) begin
         chk("glitch_p0", vq_p[0], 200);
         chk("glitch_h0", vq_h[0], 50);
         chk("glitch_p1", vq_p[1], 120);
         chk("glitch_h1", vq_h[1], 50);
         chk("glitch_p2", vq_p[2], 80);
         chk("glitch_h2", vq_h[2], 1);
      end
`endif

      chk("valid_one_cycle", dbl, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
